// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Shares a single-port word memory between a CPU port and a DMA
//            port. Single accesses are arbitrated round-robin; the DMA port
//            may lock the memory for an auto-incrementing burst.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8
) (
    input  logic              CLK,
    input  logic              RST,
    // CPU port
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    // DMA port
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [3:0]        dma_len,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic              dma_done,
    // Memory side
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic       c_ST_IDLE  = 1'b0;
    localparam logic       c_ST_BURST = 1'b1;
    localparam logic       c_PORT_CPU = 1'b0;
    localparam logic       c_PORT_DMA = 1'b1;
    localparam logic [3:0] c_MAX_LEN  = 4'(MAX_BURST);

    logic              r_state;
    logic              w_state_nxt;
    logic              r_last;
    logic              w_last_nxt;
    logic [3:0]        r_beat_cnt;
    logic [3:0]        w_beat_cnt_nxt;
    logic [ADDR_W-1:0] r_burst_addr;
    logic [ADDR_W-1:0] w_burst_addr_nxt;
    logic              r_burst_we;
    logic              w_burst_we_nxt;

    logic              w_cpu_gnt;
    logic              w_dma_gnt;
    logic [3:0]        w_eff_len;

    logic              w_issue;
    logic              w_issue_we;
    logic [ADDR_W-1:0] w_issue_addr;
    logic [DATA_W-1:0] w_issue_wdata;
    logic              w_issue_owner;
    logic              w_final_beat;
    logic              w_early_end;

    logic              r_owner;
    logic              r_done_pend;

    assign cpu_gnt = w_cpu_gnt;
    assign dma_gnt = w_dma_gnt;

    // Effective burst length: zero means one beat, long requests are clamped
    always_comb begin
        if (dma_len == 4'd0) begin
            w_eff_len = 4'd1;
        end else if (dma_len > c_MAX_LEN) begin
            w_eff_len = c_MAX_LEN;
        end else begin
            w_eff_len = dma_len;
        end
    end

    // Grant decision, winning command selection and next-state logic
    always_comb begin
        w_cpu_gnt        = 1'b0;
        w_dma_gnt        = 1'b0;
        w_state_nxt      = r_state;
        w_last_nxt       = r_last;
        w_beat_cnt_nxt   = r_beat_cnt;
        w_burst_addr_nxt = r_burst_addr;
        w_burst_we_nxt   = r_burst_we;
        w_issue          = 1'b0;
        w_issue_we       = 1'b0;
        w_issue_addr     = mem_addr;
        w_issue_wdata    = mem_wdata;
        w_issue_owner    = c_PORT_CPU;
        w_final_beat     = 1'b0;
        w_early_end      = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                // On a tie the port that was not served last wins
                w_cpu_gnt = cpu_req & (~dma_req | (r_last == c_PORT_DMA));
                w_dma_gnt = dma_req & ~w_cpu_gnt;

                if (w_cpu_gnt) begin
                    w_issue       = 1'b1;
                    w_issue_we    = cpu_we;
                    w_issue_addr  = cpu_addr;
                    w_issue_wdata = cpu_wdata;
                    w_issue_owner = c_PORT_CPU;
                    w_last_nxt    = c_PORT_CPU;
                end else if (w_dma_gnt) begin
                    w_issue       = 1'b1;
                    w_issue_we    = dma_we;
                    w_issue_addr  = dma_addr;
                    w_issue_wdata = dma_wdata;
                    w_issue_owner = c_PORT_DMA;
                    w_last_nxt    = c_PORT_DMA;
                    if (w_eff_len > 4'd1) begin
                        w_state_nxt      = c_ST_BURST;
                        w_beat_cnt_nxt   = w_eff_len - 4'd1;
                        w_burst_addr_nxt = dma_addr + 1'b1;
                        w_burst_we_nxt   = dma_we;
                    end else begin
                        w_final_beat = 1'b1;
                    end
                end
            end

            default: begin
                // Burst owns the memory; a gap in dma_req abandons the rest
                w_dma_gnt  = dma_req;
                w_last_nxt = c_PORT_DMA;
                if (dma_req) begin
                    w_issue          = 1'b1;
                    w_issue_we       = r_burst_we;
                    w_issue_addr     = r_burst_addr;
                    w_issue_wdata    = dma_wdata;
                    w_issue_owner    = c_PORT_DMA;
                    w_burst_addr_nxt = r_burst_addr + 1'b1;
                    w_beat_cnt_nxt   = r_beat_cnt - 4'd1;
                    if (r_beat_cnt == 4'd1) begin
                        w_state_nxt  = c_ST_IDLE;
                        w_final_beat = 1'b1;
                    end
                end else begin
                    w_state_nxt = c_ST_IDLE;
                    w_early_end = 1'b1;
                end
            end
        endcase
    end

    // Arbiter state registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= c_ST_IDLE;
            r_last       <= c_PORT_DMA;
            r_beat_cnt   <= 4'd0;
            r_burst_addr <= '0;
            r_burst_we   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last       <= w_last_nxt;
            r_beat_cnt   <= w_beat_cnt_nxt;
            r_burst_addr <= w_burst_addr_nxt;
            r_burst_we   <= w_burst_we_nxt;
        end
    end

    // Memory command register; address and data hold when nothing is issued
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mem_cs      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            r_owner     <= c_PORT_CPU;
            r_done_pend <= 1'b0;
        end else begin
            mem_cs      <= w_issue;
            mem_we      <= w_issue_we;
            r_owner     <= w_issue_owner;
            r_done_pend <= w_final_beat;
            if (w_issue) begin
                mem_addr  <= w_issue_addr;
                mem_wdata <= w_issue_wdata;
            end
        end
    end

    // Route read data to the issuing port and time the burst-done pulse
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cpu_rdata  <= '0;
            cpu_rvalid <= 1'b0;
            dma_rdata  <= '0;
            dma_rvalid <= 1'b0;
            dma_done   <= 1'b0;
        end else begin
            cpu_rvalid <= mem_cs & ~mem_we & (r_owner == c_PORT_CPU);
            dma_rvalid <= mem_cs & ~mem_we & (r_owner == c_PORT_DMA);
            if (mem_cs & ~mem_we & (r_owner == c_PORT_CPU)) begin
                cpu_rdata <= mem_rdata;
            end
            if (mem_cs & ~mem_we & (r_owner == c_PORT_DMA)) begin
                dma_rdata <= mem_rdata;
            end
            dma_done <= r_done_pend | w_early_end;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Purpose  : Self-checking bench for mem_bus_arbiter with a behavioural
//            memory and a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int ADDR_W    = 7;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 8;
    localparam int DEPTH     = 128;
    localparam int NC        = 40;

    logic              CLK = 1'b0;
    logic              RST;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt, cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              dma_req, dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [3:0]        dma_len;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt, dma_rvalid, dma_done;
    logic [DATA_W-1:0] dma_rdata;
    logic              mem_cs, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [DATA_W-1:0] ram     [DEPTH];
    logic [DATA_W-1:0] ram_q;
    logic [DATA_W-1:0] ref_mem [DEPTH];

    int errors = 0;
    int checks = 0;
    int n_cpu_rv, n_dma_rv, n_done, n_overlap;
    logic [DATA_W-1:0] dma_rd_q [$];

    logic              exp_crv [NC+2];
    logic [DATA_W-1:0] exp_crd [NC+2];
    logic              exp_drv [NC+2];
    logic [DATA_W-1:0] exp_drd [NC+2];
    logic              exp_dn  [NC+2];

    mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .CLK(CLK), .RST(RST),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_len(dma_len),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata),
        .dma_rvalid(dma_rvalid), .dma_done(dma_done),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;

    assign mem_rdata = ram_q;

    // Single-port memory acting on the falling edge inside each memory cycle
    always @(negedge CLK) begin
        if (mem_cs) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        ram_q <= ram[mem_addr];
        end
    end

    // Event counters for pulse-type outputs
    always @(negedge CLK) begin
        if (!RST) begin
            if (cpu_rvalid) n_cpu_rv++;
            if (dma_rvalid) begin
                n_dma_rv++;
                dma_rd_q.push_back(dma_rdata);
            end
            if (dma_done) n_done++;
            if (cpu_gnt && dma_gnt) n_overlap++;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr_mon();
        n_cpu_rv  = 0;
        n_dma_rv  = 0;
        n_done    = 0;
        n_overlap = 0;
        dma_rd_q.delete();
    endtask

    task automatic idle_inputs();
        cpu_req   = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req   = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_len = 4'd0; dma_wdata = '0;
    endtask

    function automatic int eff_len(input logic [3:0] len);
        if (len == 4'd0) return 1;
        if (int'(len) > MAX_BURST) return MAX_BURST;
        return int'(len);
    endfunction

    task automatic test_reset();
        RST = 1'b1;
        idle_inputs();
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({mem_cs, mem_we, cpu_rvalid, dma_rvalid, dma_done, cpu_gnt, dma_gnt} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got cs=%b we=%b crv=%b drv=%b done=%b cg=%b dg=%b expected all 0",
                     mem_cs, mem_we, cpu_rvalid, dma_rvalid, dma_done, cpu_gnt, dma_gnt);
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0 || cpu_rdata !== '0 || dma_rdata !== '0) begin
            errors++;
            $display("FAIL reset_data: got addr=%0h wdata=%0h crd=%0h drd=%0h expected 0",
                     mem_addr, mem_wdata, cpu_rdata, dma_rdata);
        end
        RST = 1'b0;
        // Put a single-beat DMA read in flight, then reset mid-cycle
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 7'd3; dma_len = 4'd1;
        tick();
        dma_req = 1'b0;
        checks++;
        if (mem_cs !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_accept: mem_cs got %b expected 1", mem_cs);
        end
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if ({mem_cs, mem_we, cpu_rvalid, dma_rvalid, dma_done} !== 5'b0) begin
            errors++;
            $display("FAIL reset_async: got cs=%b we=%b crv=%b drv=%b done=%b expected all 0",
                     mem_cs, mem_we, cpu_rvalid, dma_rvalid, dma_done);
        end
        tick();
        RST = 1'b0;
        clr_mon();
        repeat (3) tick();
        checks++;
        if (n_dma_rv != 0 || n_cpu_rv != 0 || n_done != 0) begin
            errors++;
            $display("FAIL reset_abandon: got rvalids=%0d/%0d done=%0d expected 0/0/0",
                     n_cpu_rv, n_dma_rv, n_done);
        end
    endtask

    // Fill the whole memory with 16 back-to-back 8-beat DMA write bursts
    task automatic test_fill();
        int gnt_miss = 0;
        clr_mon();
        dma_req = 1'b1; dma_we = 1'b1; dma_len = 4'd8;
        for (int i = 0; i < DEPTH; i++) begin
            dma_addr  = 7'((i / 8) * 8);
            dma_wdata = $urandom;
            @(negedge CLK);
            if (dma_gnt !== 1'b1) gnt_miss++;
            ref_mem[i] = dma_wdata;
            tick();
        end
        dma_req = 1'b0;
        repeat (2) tick();
        checks++;
        if (gnt_miss != 0 || n_done != 16) begin
            errors++;
            $display("FAIL fill_bursts: got missed_gnt=%0d done=%0d expected 0 and 16", gnt_miss, n_done);
        end
    endtask

    task automatic test_round_robin();
        logic exp_c;
        clr_mon();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'd10;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 7'd20; dma_len = 4'd1;
        for (int i = 0; i < 6; i++) begin
            exp_c = (i % 2 == 0);
            @(negedge CLK);
            checks++;
            if (cpu_gnt !== exp_c || dma_gnt !== !exp_c) begin
                errors++;
                $display("FAIL rr_order slot %0d: got cpu=%b dma=%b expected cpu=%b dma=%b",
                         i, cpu_gnt, dma_gnt, exp_c, !exp_c);
            end
            tick();
        end
        idle_inputs();
        repeat (3) tick();
        checks++;
        if (n_done != 3 || n_overlap != 0 || n_cpu_rv != 3 || n_dma_rv != 3) begin
            errors++;
            $display("FAIL rr_counts: got done=%0d overlap=%0d crv=%0d drv=%0d expected 3 0 3 3",
                     n_done, n_overlap, n_cpu_rv, n_dma_rv);
        end
    endtask

    task automatic test_cpu_read();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 7'd5; cpu_wdata = 32'hDEADBEEF;
        tick();
        ref_mem[5] = 32'hDEADBEEF;
        cpu_we = 1'b0;
        @(negedge CLK);
        checks++;
        if (cpu_gnt !== 1'b1) begin
            errors++;
            $display("FAIL cpu_read_gnt: got %b expected 1", cpu_gnt);
        end
        tick();
        cpu_req = 1'b0;
        checks++;
        if (mem_cs !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 7'd5 || cpu_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL cpu_read_cmd: got cs=%b we=%b addr=%0d rv=%b expected 1 0 5 0",
                     mem_cs, mem_we, mem_addr, cpu_rvalid);
        end
        tick();
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF || mem_cs !== 1'b0) begin
            errors++;
            $display("FAIL cpu_read_data: got rv=%b data=%h cs=%b expected 1 deadbeef 0",
                     cpu_rvalid, cpu_rdata, mem_cs);
        end
        tick();
        checks++;
        if (cpu_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL cpu_read_pulse: rvalid got %b expected 0", cpu_rvalid);
        end
    endtask

    task automatic test_dma_wrap();
        int bad = 0;
        clr_mon();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'd40;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 7'd126; dma_len = 4'd4; dma_wdata = 32'd1;
        for (int b = 0; b < 4; b++) begin
            @(negedge CLK);
            if (dma_gnt !== 1'b1 || cpu_gnt !== 1'b0) bad++;
            ref_mem[(126 + b) % DEPTH] = DATA_W'(b + 1);
            tick();
            dma_wdata = DATA_W'(b + 2);
        end
        dma_req = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL wrap_lock: got %0d bad grant cycles expected 0", bad);
        end
        @(negedge CLK);
        checks++;
        if (cpu_gnt !== 1'b1) begin
            errors++;
            $display("FAIL wrap_cpu_after: cpu_gnt got %b expected 1", cpu_gnt);
        end
        tick();
        cpu_req = 1'b0;
        repeat (2) tick();
        checks++;
        if (ram[126] !== 32'd1 || ram[127] !== 32'd2 || ram[0] !== 32'd3 || ram[1] !== 32'd4) begin
            errors++;
            $display("FAIL wrap_data: got %0d %0d %0d %0d expected 1 2 3 4", ram[126], ram[127], ram[0], ram[1]);
        end
        checks++;
        if (n_done != 1 || n_cpu_rv != 1 || cpu_rdata !== ref_mem[40]) begin
            errors++;
            $display("FAIL wrap_done: got done=%0d crv=%0d crd=%h expected 1 1 %h",
                     n_done, n_cpu_rv, cpu_rdata, ref_mem[40]);
        end
    endtask

    task automatic test_early_term();
        clr_mon();
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 7'd50; dma_len = 4'd4;
        repeat (2) tick();
        dma_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'd60;
        @(negedge CLK);
        checks++;
        if (cpu_gnt !== 1'b0) begin
            errors++;
            $display("FAIL early_cpu_blocked: cpu_gnt got %b expected 0", cpu_gnt);
        end
        tick();
        checks++;
        if (dma_done !== 1'b1) begin
            errors++;
            $display("FAIL early_done: dma_done got %b expected 1", dma_done);
        end
        @(negedge CLK);
        checks++;
        if (cpu_gnt !== 1'b1) begin
            errors++;
            $display("FAIL early_cpu_next: cpu_gnt got %b expected 1", cpu_gnt);
        end
        tick();
        cpu_req = 1'b0;
        repeat (3) tick();
        checks++;
        if (n_dma_rv != 2 || n_done != 1 || dma_rd_q.size() != 2) begin
            errors++;
            $display("FAIL early_counts: got drv=%0d done=%0d expected 2 1", n_dma_rv, n_done);
        end else if (dma_rd_q[0] !== ref_mem[50] || dma_rd_q[1] !== ref_mem[51]) begin
            errors++;
            $display("FAIL early_data: got %h %h expected %h %h", dma_rd_q[0], dma_rd_q[1], ref_mem[50], ref_mem[51]);
        end
    endtask

    task automatic test_len_clamp();
        logic [3:0] lens [2];
        int         exp_beats [2];
        lens[0] = 4'd0;  exp_beats[0] = 1;
        lens[1] = 4'd15; exp_beats[1] = 8;
        for (int t = 0; t < 2; t++) begin
            clr_mon();
            dma_req = 1'b1; dma_we = 1'b0; dma_addr = 7'd100; dma_len = lens[t];
            repeat (exp_beats[t]) tick();
            dma_req = 1'b0;
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'd2;
            @(negedge CLK);
            checks++;
            if (cpu_gnt !== 1'b1) begin
                errors++;
                $display("FAIL clamp_idle len=%0d: cpu_gnt got %b expected 1", lens[t], cpu_gnt);
            end
            tick();
            cpu_req = 1'b0;
            repeat (3) tick();
            checks++;
            if (n_dma_rv != exp_beats[t] || n_done != 1) begin
                errors++;
                $display("FAIL clamp_beats len=%0d: got beats=%0d done=%0d expected %0d 1",
                         lens[t], n_dma_rv, n_done, exp_beats[t]);
            end
        end
    endtask

    task automatic test_random_bursts();
        logic [ADDR_W-1:0] a;
        logic [3:0]        len;
        logic              we;
        int                L, gmiss, dbad;
        logic [DATA_W-1:0] cexp;
        for (int t = 0; t < 6; t++) begin
            clr_mon();
            a = 7'($urandom); len = 4'($urandom); we = 1'($urandom_range(0, 1));
            L = eff_len(len);
            gmiss = 0;
            dma_req = 1'b1; dma_we = we; dma_addr = a; dma_len = len; dma_wdata = $urandom;
            for (int b = 0; b < L; b++) begin
                @(negedge CLK);
                if (dma_gnt !== 1'b1) gmiss++;
                if (we) ref_mem[(int'(a) + b) % DEPTH] = dma_wdata;
                tick();
                dma_wdata = $urandom;
            end
            dma_req = 1'b0;
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'($urandom);
            cexp = ref_mem[cpu_addr];
            @(negedge CLK);
            if (cpu_gnt !== 1'b1) gmiss++;
            tick();
            cpu_req = 1'b0;
            repeat (3) tick();
            checks++;
            if (gmiss != 0 || n_done != 1 || n_dma_rv != (we ? 0 : L)) begin
                errors++;
                $display("FAIL rand_burst %0d: got gnt_miss=%0d done=%0d drv=%0d expected 0 1 %0d",
                         t, gmiss, n_done, n_dma_rv, we ? 0 : L);
            end
            dbad = 0;
            if (!we) begin
                for (int i = 0; i < L && i < dma_rd_q.size(); i++)
                    if (dma_rd_q[i] !== ref_mem[(int'(a) + i) % DEPTH]) dbad++;
            end
            checks++;
            if (dbad != 0 || n_cpu_rv != 1 || cpu_rdata !== cexp) begin
                errors++;
                $display("FAIL rand_burst_data %0d: got bad_beats=%0d crv=%0d crd=%h expected 0 1 %h",
                         t, dbad, n_cpu_rv, cpu_rdata, cexp);
            end
        end
    endtask

    // Random single accesses from both ports against a transaction model
    task automatic test_random_contention();
        logic m_last;
        logic exp_c, exp_d, c_took, d_took;
        logic [DATA_W-1:0] wd;
        wd = $urandom;
        idle_inputs();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 7'd9; cpu_wdata = wd;
        tick();
        ref_mem[9] = wd;
        cpu_req = 1'b0;
        repeat (2) tick();
        m_last = 1'b0;
        c_took = 1'b0; d_took = 1'b0;
        for (int n = 0; n < NC + 2; n++) begin
            exp_crv[n] = 1'b0; exp_drv[n] = 1'b0; exp_dn[n] = 1'b0;
            exp_crd[n] = '0;   exp_drd[n] = '0;
        end
        for (int n = 0; n < NC + 2; n++) begin
            if (n < NC) begin
                if (!cpu_req || c_took) begin
                    cpu_req = 1'($urandom_range(0, 1)); cpu_we = 1'($urandom_range(0, 1));
                    cpu_addr = 7'($urandom); cpu_wdata = $urandom;
                end
                if (!dma_req || d_took) begin
                    dma_req = 1'($urandom_range(0, 1)); dma_we = 1'($urandom_range(0, 1));
                    dma_addr = 7'($urandom); dma_wdata = $urandom;
                    dma_len = 4'($urandom_range(0, 1));
                end
            end else begin
                idle_inputs();
            end
            exp_c = cpu_req && (!dma_req || m_last);
            exp_d = dma_req && !exp_c;
            @(negedge CLK);
            checks++;
            if (cpu_gnt !== exp_c || dma_gnt !== exp_d) begin
                errors++;
                $display("FAIL cont_gnt cycle %0d: got cpu=%b dma=%b expected cpu=%b dma=%b",
                         n, cpu_gnt, dma_gnt, exp_c, exp_d);
            end
            if (exp_c) begin
                m_last = 1'b0;
                if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
                else begin
                    exp_crv[n+1] = 1'b1;
                    exp_crd[n+1] = ref_mem[cpu_addr];
                end
            end
            if (exp_d) begin
                m_last = 1'b1;
                exp_dn[n+1] = 1'b1;
                if (dma_we) ref_mem[dma_addr] = dma_wdata;
                else begin
                    exp_drv[n+1] = 1'b1;
                    exp_drd[n+1] = ref_mem[dma_addr];
                end
            end
            c_took = exp_c; d_took = exp_d;
            tick();
            checks++;
            if (cpu_rvalid !== exp_crv[n] || dma_rvalid !== exp_drv[n] || dma_done !== exp_dn[n] ||
                (exp_crv[n] && cpu_rdata !== exp_crd[n]) || (exp_drv[n] && dma_rdata !== exp_drd[n])) begin
                errors++;
                $display("FAIL cont_ret edge %0d: got crv=%b crd=%h drv=%b drd=%h done=%b expected %b %h %b %h %b",
                         n, cpu_rvalid, cpu_rdata, dma_rvalid, dma_rdata, dma_done,
                         exp_crv[n], exp_crd[n], exp_drv[n], exp_drd[n], exp_dn[n]);
            end
        end
    endtask

    task automatic test_final_memory();
        int bad = 0;
        for (int i = 0; i < DEPTH; i++)
            if (ram[i] !== ref_mem[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL final_memory: got %0d differing words expected 0", bad);
        end
    endtask

    initial begin
        clr_mon();
        test_reset();
        test_fill();
        test_round_robin();
        test_cpu_read();
        test_dma_wrap();
        test_early_term();
        test_len_clamp();
        test_random_bursts();
        test_random_contention();
        test_final_memory();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
